// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Definitions shared by the UART TX and RX engines. Holds the
//             bit-time width default, the receive FSM state codes, the
//             frame-length helper and the parity helper.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Width of the bit-time count k produced by the BAUD decoder
    localparam int c_KW_DEFAULT = 19;

    // Receive FSM state encoding (binary)
    localparam int                    c_RX_ST_W  = 2;
    localparam logic [c_RX_ST_W-1:0]  c_RX_IDLE  = 2'd0;
    localparam logic [c_RX_ST_W-1:0]  c_RX_START = 2'd1;
    localparam logic [c_RX_ST_W-1:0]  c_RX_DATA  = 2'd2;
    localparam logic [c_RX_ST_W-1:0]  c_RX_DONE  = 2'd3;

    // Seven data bits plus one stop bit: the shortest frame after the start bit
    localparam logic [3:0] c_NB_BASE = 4'd8;

    // Number of bits sampled after the start bit: data + optional parity + stop
    function automatic logic [3:0] frame_nb(input logic eight, input logic pen);
        return c_NB_BASE + {3'b000, eight} + {3'b000, pen};
    endfunction

    // Parity bit value for a data byte: even -> ^data, odd -> ~^data
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sync
//  Purpose  : Metastability synchroniser for the RX pin plus a one-clock
//             delayed copy used to detect the falling edge of a start bit.
//             All flops reset to 1 so that an idle line produces no edge.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2          // at least 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_start
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_p;

    // Shift the pin through the synchroniser chain and keep the previous synchronised value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_rx_p <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_rx_p <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rx_s  = r_sync[SYNC_STAGES-1];
    // Only a genuine high-to-low transition counts; a line that is already low does not
    assign o_start = r_rx_p & ~o_rx_s;

endmodule
`default_nettype wire

// File: rtl/uart_rx_engine.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_engine
//  Purpose  : UART receive engine. Finds the start bit by falling edge,
//             confirms it at mid-bit, samples 7/8 data bits, optional parity
//             and the stop bit once per bit time, then presents the byte with
//             RXRDY and PERR/FERR/OVF status until the processor reads it.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int KW          = c_KW_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RX,
    input  logic [KW-1:0] k,
    input  logic          EIGHT,
    input  logic          PEN,
    input  logic          OHEL,
    input  logic          READS,
    output logic [7:0]    RDATA,
    output logic          RXRDY,
    output logic          PERR,
    output logic          FERR,
    output logic          OVF
);

    // ------------------------------------------------------------------
    // Pin synchroniser and start-edge detector
    // ------------------------------------------------------------------
    logic w_rx_s;
    logic w_start;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_rx    (RX),
        .o_rx_s  (w_rx_s),
        .o_start (w_start)
    );

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    logic [c_RX_ST_W-1:0] r_state;
    logic [KW-1:0]        r_btc;
    logic [3:0]           r_bitcnt;
    logic [9:0]           r_sr;
    logic                 r_cfg_eight;
    logic                 r_cfg_pen;
    logic                 r_cfg_ohel;

    logic [KW-1:0]        w_half;
    logic                 w_mid;
    logic                 w_btu;
    logic [3:0]           w_nb;
    logic                 w_last;

    assign w_half = k >> 1;
    assign w_mid  = (r_btc == w_half);
    assign w_btu  = (r_btc == k);
    // Frame length follows the configuration captured when the start bit was confirmed
    assign w_nb   = frame_nb(r_cfg_eight, r_cfg_pen);
    assign w_last = ((r_bitcnt + 4'd1) == w_nb);

    // Receive FSM with its bit-time counter, bit counter, shift register and config latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_RX_IDLE;
            r_btc       <= '0;
            r_bitcnt    <= 4'd0;
            r_sr        <= 10'd0;
            r_cfg_eight <= 1'b0;
            r_cfg_pen   <= 1'b0;
            r_cfg_ohel  <= 1'b0;
        end else begin
            case (r_state)
                c_RX_IDLE: begin
                    r_btc <= '0;
                    if (w_start) begin
                        r_state <= c_RX_START;
                    end
                end
                c_RX_START: begin
                    if (w_mid) begin
                        r_btc <= '0;
                        if (w_rx_s) begin
                            // Line back high at mid-bit: a glitch, not a start bit
                            r_state <= c_RX_IDLE;
                        end else begin
                            r_state     <= c_RX_DATA;
                            r_bitcnt    <= 4'd0;
                            r_cfg_eight <= EIGHT;
                            r_cfg_pen   <= PEN;
                            r_cfg_ohel  <= OHEL;
                        end
                    end else begin
                        r_btc <= r_btc + KW'(1);
                    end
                end
                c_RX_DATA: begin
                    if (w_btu) begin
                        r_btc    <= '0;
                        r_sr     <= {w_rx_s, r_sr[9:1]};
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (w_last) begin
                            r_state <= c_RX_DONE;
                        end
                    end else begin
                        r_btc <= r_btc + KW'(1);
                    end
                end
                c_RX_DONE: begin
                    r_btc   <= '0;
                    r_state <= c_RX_IDLE;
                end
                default: begin
                    r_btc   <= '0;
                    r_state <= c_RX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame decode: the first received bit sits at SR[10-NB]
    // ------------------------------------------------------------------
    logic [9:0] w_a;
    logic [7:0] w_data;
    logic       w_pbit;
    logic       w_stop;
    logic       w_perr;

    assign w_a    = r_sr >> (4'd10 - w_nb);
    assign w_data = r_cfg_eight ? w_a[7:0] : {1'b0, w_a[6:0]};
    assign w_pbit = r_cfg_eight ? w_a[8] : w_a[7];
    assign w_stop = w_a[w_nb - 4'd1];
    assign w_perr = r_cfg_pen & (w_pbit != parity_bit(w_data, r_cfg_ohel));

    // ------------------------------------------------------------------
    // Status and data registers seen by the processor
    // ------------------------------------------------------------------
    logic [7:0] r_rdata;
    logic       r_rxrdy;
    logic       r_perr;
    logic       r_ferr;
    logic       r_ovf;

    // Frame completion updates everything and takes priority over a coincident read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 8'd0;
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == c_RX_DONE) begin
            r_rdata <= w_data;
            r_perr  <= w_perr;
            r_ferr  <= ~w_stop;
            // A read in this same cycle consumed the previous byte, so no overrun
            r_ovf   <= r_rxrdy & ~READS;
            r_rxrdy <= 1'b1;
        end else if (READS) begin
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end
    end

    assign RDATA = r_rdata;
    assign RXRDY = r_rxrdy;
    assign PERR  = r_perr;
    assign FERR  = r_ferr;
    assign OVF   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_engine
//  Purpose  : Self-checking bench for uart_rx_engine. A behavioural serial
//             transmitter drives RX; expected byte and flags come from the
//             frame contents and the UART framing rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_engine;

    localparam int KW   = 19;
    localparam int SYNC = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          RX    = 1'b1;
    logic [KW-1:0] k     = KW'(15);
    logic          EIGHT = 1'b1;
    logic          PEN   = 1'b0;
    logic          OHEL  = 1'b0;
    logic          READS = 1'b0;
    logic [7:0]    RDATA;
    logic          RXRDY;
    logic          PERR;
    logic          FERR;
    logic          OVF;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_engine #(
        .KW          (KW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .k     (k),
        .EIGHT (EIGHT),
        .PEN   (PEN),
        .OHEL  (OHEL),
        .READS (READS),
        .RDATA (RDATA),
        .RXRDY (RXRDY),
        .PERR  (PERR),
        .FERR  (FERR),
        .OVF   (OVF)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural transmitter: start, LSB-first data, optional parity, stop
    task automatic send_frame(input logic [7:0] b, input logic eight, input logic pen,
                              input logic ohel, input logic bad_par, input logic bad_stop,
                              input int kk);
        bit         q[$];
        logic [7:0] d;
        EIGHT = eight;
        PEN   = pen;
        OHEL  = ohel;
        d = eight ? b : {1'b0, b[6:0]};
        q.push_back(1'b0);
        for (int i = 0; i < (eight ? 8 : 7); i++) q.push_back(d[i]);
        if (pen) q.push_back((^d) ^ ohel ^ bad_par);
        q.push_back(~bad_stop);
        foreach (q[i]) begin
            RX = q[i];
            repeat (kk + 1) @(negedge clk);
        end
    endtask

    // Enough time after the last bit time for the stop sample, sync delay and DONE
    task automatic settle(input int kk);
        repeat (kk / 2 + 6) @(negedge clk);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] b, input logic eight,
                                input logic pen, input logic bad_par, input logic bad_stop,
                                input logic exp_ovf);
        check({tag, ":rxrdy"}, RXRDY, 1);
        check({tag, ":rdata"}, RDATA, eight ? b : {1'b0, b[6:0]});
        check({tag, ":perr"},  PERR,  pen & bad_par);
        check({tag, ":ferr"},  FERR,  bad_stop);
        check({tag, ":ovf"},   OVF,   exp_ovf);
    endtask

    task automatic rx_frame(input string tag, input logic [7:0] b, input logic eight,
                            input logic pen, input logic ohel, input logic bad_par,
                            input logic bad_stop, input logic exp_ovf, input int kk);
        send_frame(b, eight, pen, ohel, bad_par, bad_stop, kk);
        settle(kk);
        expect_frame(tag, b, eight, pen, bad_par, bad_stop, exp_ovf);
    endtask

    task automatic pulse_reads();
        @(negedge clk);
        READS = 1'b1;
        @(negedge clk);
        READS = 1'b0;
    endtask

    // Hard stop in case something never returns
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         kk;
        logic [7:0] b;
        logic       e, p, o, bp, bs;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst:rdata", RDATA, 0);
        check("rst:rxrdy", RXRDY, 0);
        check("rst:perr",  PERR,  0);
        check("rst:ferr",  FERR,  0);
        check("rst:ovf",   OVF,   0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // ---- 8N1 0x55 with RXRDY latency measurement ----
        lat = 0;
        fork
            send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15);
            begin
                while (!RXRDY && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        n_cmp++;
        assert (lat >= 16 * 19 / 2 + SYNC && lat <= 16 * 19 / 2 + SYNC + 2) else begin
            n_bad++;
            $error("FAIL lat8n1: observed %0d expected %0d +/- 1", lat, 16 * 19 / 2 + SYNC + 1);
        end
        settle(15);
        expect_frame("8n1_55", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_reads();
        check("read:rxrdy", RXRDY, 0);
        check("read:rdata_held", RDATA, 8'h55);

        // ---- 7-bit even parity, wrong then right parity bit ----
        rx_frame("7e_bad", 8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 15);
        pulse_reads();
        check("7e_bad:perr_clr", PERR, 0);
        rx_frame("7e_good", 8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15);
        pulse_reads();

        // ---- framing error, line held low afterwards ----
        rx_frame("ferr", 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15);
        pulse_reads();
        check("ferr:clr", FERR, 0);
        repeat (300) @(negedge clk);
        check("held_low:rxrdy", RXRDY, 0);
        RX = 1'b1;
        repeat (20) @(negedge clk);
        rx_frame("after_low", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15);
        pulse_reads();

        // ---- overrun ----
        rx_frame("ovf1", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15);
        rx_frame("ovf2", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15);
        pulse_reads();
        check("ovf:rxrdy_clr", RXRDY, 0);
        check("ovf:ovf_clr", OVF, 0);
        check("ovf:rdata_held", RDATA, 8'h22);

        // ---- READS coincident with frame completion ----
        rx_frame("pre_coinc", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15);
        fork
            send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15);
            begin
                repeat (lat - 1) @(negedge clk);
                READS = 1'b1;
                @(negedge clk);
                READS = 1'b0;
            end
        join
        settle(15);
        expect_frame("coinc", 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_reads();

        // ---- short low glitch ----
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch:rxrdy", RXRDY, 0);
        rx_frame("post_glitch", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15);
        pulse_reads();

        // ---- reset mid-frame with a byte pending ----
        rx_frame("pre_rst", 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15);
        fork
            send_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15);
            begin
                repeat (60) @(negedge clk);
                rst_n = 1'b0;
            end
        join
        check("midrst:rdata", RDATA, 0);
        check("midrst:rxrdy", RXRDY, 0);
        check("midrst:perr",  PERR,  0);
        check("midrst:ferr",  FERR,  0);
        check("midrst:ovf",   OVF,   0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst:rxrdy_after", RXRDY, 0);
        rx_frame("post_rst", 8'hC6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15);
        pulse_reads();

        // ---- loopback at k=433, every EIGHT/PEN/OHEL combination ----
        k = KW'(433);
        for (int c = 0; c < 8; c++) begin
            b = 8'($urandom);
            rx_frame($sformatf("loop%0d", c), b, c[2], c[1], c[0], 1'b0, 1'b0, 1'b0, 433);
            pulse_reads();
            repeat (20) @(negedge clk);
        end

        // ---- random bit times, configurations and injected errors ----
        for (int i = 0; i < 20; i++) begin
            kk = $urandom_range(30, 3);
            k  = KW'(kk);
            b  = 8'($urandom);
            e  = 1'($urandom);
            p  = 1'($urandom);
            o  = 1'($urandom);
            bp = ($urandom_range(3, 0) == 0);
            bs = ($urandom_range(3, 0) == 0);
            repeat (2 * (kk + 1)) @(negedge clk);
            rx_frame($sformatf("rnd%0d_k%0d", i, kk), b, e, p, o, bp, bs, 1'b0, kk);
            pulse_reads();
            RX = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
